// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_pkg;

  localparam logic [3:0] DMEM_WSTRB_FULL = 4'hF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK_RD,
    ARB_LOCK_WR
  } arb_state_t;

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/dmem_tag_fifo.sv
// rtl/dmem_tag_fifo.sv - 1-bit in-order tag FIFO recording is_read per granted transaction
module dmem_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [IW-1:0]    w_idx, r_idx;
  logic             w_wrap, r_wrap;
  logic             push_en, pop_en;

  // Index wraps at DEPTH and toggles the wrap bit, so any depth works with the MSB compare.
  function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  assign full     = (w_idx == r_idx) && (w_wrap != r_wrap);
  assign empty    = (w_idx == r_idx) && (w_wrap == r_wrap);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      w_idx  <= '0;
      r_idx  <= '0;
      w_wrap <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (push_en) begin
        mem[w_idx] <= push_data;
        w_idx      <= idx_next(w_idx);
        if (w_idx == IW'(DEPTH - 1)) w_wrap <= ~w_wrap;
      end
      if (pop_en) begin
        r_idx <= idx_next(r_idx);
        if (r_idx == IW'(DEPTH - 1)) r_wrap <= ~r_wrap;
      end
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - arbitrates write-buffer drains and reads onto one data-memory bus
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic [3:0]  wb_wstrb_i,
  output logic        wb_ready_o,
  input  logic        rd_valid_i,
  input  logic [31:0] rd_addr_i,
  output logic        rd_ready_o,
  output logic        rd_rvalid_o,
  output logic [31:0] rd_rdata_o,
  output logic        rd_err_o,
  output logic        wr_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t  state, state_n;
  logic [SW-1:0] starve_cnt;
  logic        post_rst_quiet;
  logic        sel_wr, sel_rd, grant, resp_fire;
  logic        tag_head, tag_full, tag_empty;
  dmem_req_t   req;
  dmem_rsp_t   rsp;

  dmem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (sel_rd),
    .pop       (resp_fire),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB_IDLE;
      starve_cnt     <= '0;
      post_rst_quiet <= 1'b1;
    end else begin
      state <= state_n;
      if (grant) post_rst_quiet <= 1'b0;
      if (!wb_valid_i || (grant && sel_wr))
        starve_cnt <= '0;
      else if (grant && sel_rd && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_comb begin
    sel_wr  = 1'b0;
    sel_rd  = 1'b0;
    state_n = ARB_IDLE;
    // A response arriving while full frees a slot only from the next cycle on.
    if (!rst && !tag_full) begin
      case (state)
        ARB_LOCK_WR: sel_wr = 1'b1;
        ARB_LOCK_RD: sel_rd = 1'b1;
        default: begin
          sel_wr = wb_valid_i && (!rd_valid_i || same_word(wb_addr_i, rd_addr_i) ||
                                  starve_cnt == SW'(STARVE_LIMIT));
          sel_rd = rd_valid_i && !sel_wr;
        end
      endcase
    end
    if ((sel_wr || sel_rd) && !bus_gnt_i)
      state_n = sel_wr ? ARB_LOCK_WR : ARB_LOCK_RD;

    req = '0;
    if (sel_wr) begin
      req.we    = 1'b1;
      req.addr  = wb_addr_i;
      req.wdata = wb_wdata_i;
      req.wstrb = wb_wstrb_i;
    end else if (sel_rd) begin
      req.addr  = rd_addr_i;
      req.wstrb = DMEM_WSTRB_FULL;
    end
    grant = (sel_wr || sel_rd) && bus_gnt_i;

    rsp.data  = bus_rdata_i;
    rsp.err   = bus_err_i;
    resp_fire = !rst && bus_rvalid_i && !tag_empty;
  end

  assign bus_req_o   = sel_wr || sel_rd;
  assign bus_we_o    = req.we;
  assign bus_addr_o  = req.addr;
  assign bus_wdata_o = req.wdata;
  assign bus_wstrb_o = req.wstrb;
  assign wb_ready_o  = grant && sel_wr;
  assign rd_ready_o  = grant && sel_rd;

  assign rd_rvalid_o = resp_fire && tag_head;
  assign rd_rdata_o  = rd_rvalid_o ? rsp.data : '0;
  assign rd_err_o    = rd_rvalid_o && rsp.err;
  assign wr_err_o    = resp_fire && !tag_head && rsp.err;

  // Stale responses from before reset are tolerated until the first new grant.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(bus_rvalid_i && tag_empty && !post_rst_quiet));

endmodule
